bsg_trace_node_master_mc: RTL and testbench

- Multi-channel trace-replay master for memory-end testbenches.
- Steps through a trace ROM of command words and drives or checks up to num_ch_p independent valid/ready channels.
- Adds per-op channel select, timed waits, a receive-any op, a stall timeout and latched mismatch reporting to single-channel replay.
- Sits between per-test trace ROMs (external, combinational) and the DUT ring/LCE ports.

---
 rtl/bsg_trace_node_master_mc_pkg.sv | 43 ++++
 rtl/bsg_trace_node_master_mc_if.sv | 34 +++
 rtl/bsg_trace_mc_stall_timer.sv | 39 +++
 rtl/bsg_trace_node_master_mc.sv | 209 ++++++++++++++++++++
 tb/tb_bsg_trace_node_master_mc.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_trace_node_master_mc_pkg.sv
// Shared types for the multi-channel trace-replay master: opcodes, FSM states, ROM word layout.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.

`ifndef BSG_TRACE_MC_ROM_WORD_S
// ROM word {op, ch, payload}; widths depend on the instantiating module's parameters,
// so the layout is a macro rather than a package typedef.
`define BSG_TRACE_MC_ROM_WORD_S(ch_w, ring_w) \
    struct packed { \
        logic [3:0]          op; \
        logic [(ch_w)-1:0]   ch; \
        logic [(ring_w)-1:0] payload; \
    }
`endif

package bsg_trace_mc_pkg;

    typedef enum logic [3:0] {
        e_nop      = 4'd0,
        e_send     = 4'd1,
        e_recv     = 4'd2,
        e_done     = 4'd3,
        e_finish   = 4'd4,
        e_wait     = 4'd5,
        e_recv_any = 4'd6
    } op_e;

    typedef enum logic [1:0] {
        eRUN  = 2'd0,
        eWAIT = 2'd1,
        eHALT = 2'd2
    } state_e;

    // Channel field width; a single channel still carries a 1-bit field.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_trace_node_master_mc_if.sv
// Channel bundle and trace-ROM port between the replay master and the DUT side.
// Latency: none (wires only).
// Backpressure: carries per-channel valid/ready (inbound) and valid/yumi (outbound).
interface bsg_trace_node_master_mc_if #(
    parameter int num_ch_p         = 2,
    parameter int ring_width_p     = 64,
    parameter int rom_addr_width_p = 10
);
    import bsg_trace_mc_pkg::*;

    localparam int ch_w  = ch_width(num_ch_p);
    localparam int rom_w = 4 + ch_w + ring_width_p;

    logic [num_ch_p-1:0]              v_i;
    logic [num_ch_p*ring_width_p-1:0] data_i;
    logic [num_ch_p-1:0]              ready_o;
    logic [num_ch_p-1:0]              v_o;
    logic [num_ch_p*ring_width_p-1:0] data_o;
    logic [num_ch_p-1:0]              yumi_i;
    logic [rom_addr_width_p-1:0]      rom_addr_o;
    logic [rom_w-1:0]                 rom_data_i;

    // Replay master side.
    modport master (
        input  v_i, data_i, yumi_i, rom_data_i,
        output ready_o, v_o, data_o, rom_addr_o
    );

    // DUT / ROM side.
    modport slave (
        output v_i, data_i, yumi_i, rom_data_i,
        input  ready_o, v_o, data_o, rom_addr_o
    );
endinterface

// File: rtl/bsg_trace_mc_stall_timer.sv
// Shared stall/wait counter: counts up while a handshake stalls, down while a wait op runs.
// Latency: flags are combinational from the registered count; updates take effect next cycle.
// Backpressure: none; the owner decides when to load, count or clear.
module bsg_trace_mc_stall_timer #(
    parameter int cnt_w_p   = 16,
    parameter int timeout_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               i_load,
    input  logic [cnt_w_p-1:0] i_load_val,
    input  logic               i_inc,
    input  logic               i_dec,
    input  logic               i_clr,
    output logic               o_hit_one,
    output logic               o_hit_timeout
);
    localparam logic [cnt_w_p-1:0] lp_one  = cnt_w_p'(1);
    // The stall that would make the count reach timeout_p is the one being flagged.
    localparam logic [cnt_w_p-1:0] lp_last = cnt_w_p'((timeout_p > 0) ? (timeout_p - 1) : 0);

    logic [cnt_w_p-1:0] r_cnt;

    // Counter register: clear wins, then load, then saturating count.
    always_ff @(posedge clk_i) begin
        if (reset_i || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + lp_one;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - lp_one;
        end
    end

    assign o_hit_one     = (r_cnt == lp_one);
    assign o_hit_timeout = (timeout_p != 0) && (r_cnt == lp_last);
endmodule

// File: rtl/bsg_trace_node_master_mc.sv
// Multi-channel trace replay: steps a combinational trace ROM, sends/checks per-channel traffic.
// Latency: one ROM word per cycle at best; send/recv retire in the handshake cycle.
// Backpressure: holds v_o/ready_o on the selected channel until yumi_i/v_i; en_i low freezes all.
module bsg_trace_node_master_mc #(
    parameter int num_ch_p         = 2,
    parameter int ring_width_p     = 64,
    parameter int rom_addr_width_p = 10,
    parameter int cycle_width_p    = 16,
    parameter int timeout_p        = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    bsg_trace_node_master_mc_if.master  bus,
    output logic                        done_o,
    output logic                        error_o,
    output logic [rom_addr_width_p-1:0] error_addr_o
);
    import bsg_trace_mc_pkg::*;

    localparam int lp_ch_w  = ch_width(num_ch_p);
    localparam int lp_cnt_w = max_int(cycle_width_p, $clog2(timeout_p + 1));

    localparam logic [rom_addr_width_p-1:0] lp_addr_one = rom_addr_width_p'(1);
    localparam logic [cycle_width_p-1:0]    lp_cyc_one  = cycle_width_p'(1);

    typedef `BSG_TRACE_MC_ROM_WORD_S(lp_ch_w, ring_width_p) rom_word_s;

    state_e                          r_state;
    state_e                          w_state_nxt;
    logic [rom_addr_width_p-1:0]     r_addr;
    logic                            r_done;
    logic                            r_err;
    logic [rom_addr_width_p-1:0]     r_err_addr;

    rom_word_s                       w_word;
    logic                            w_ch_ok;
    logic [num_ch_p-1:0]             w_sel;
    logic [num_ch_p*ring_width_p-1:0] w_send_dat;
    logic [ring_width_p-1:0]         w_rdat;
    logic                            w_v_sel;
    logic                            w_yumi_sel;
    logic [cycle_width_p-1:0]        w_wait_n;
    logic [lp_cnt_w-1:0]             w_load_val;

    logic                            w_adv;
    logic                            w_err;
    logic                            w_set_done;
    logic                            w_stall;
    logic                            w_load;
    logic                            w_inc;
    logic                            w_dec;
    logic                            w_hit_one;
    logic                            w_hit_to;
    logic [num_ch_p-1:0]             w_v_o;
    logic [num_ch_p-1:0]             w_ready_o;
    logic [num_ch_p*ring_width_p-1:0] w_data_o;

    assign w_word     = bus.rom_data_i;
    assign w_ch_ok    = (int'(w_word.ch) < num_ch_p);
    assign w_wait_n   = w_word.payload[cycle_width_p-1:0];
    // Decode cycle counts as the first wait cycle, so the counter starts at N-1.
    assign w_load_val = lp_cnt_w'(w_wait_n - lp_cyc_one);

    // Channel select: one-hot of the ROM channel, plus its inbound data and handshakes.
    always_comb begin
        w_sel      = '0;
        w_send_dat = '0;
        w_rdat     = '0;
        for (int c = 0; c < num_ch_p; c++) begin
            if (int'(w_word.ch) == c) begin
                w_sel[c]                                  = 1'b1;
                w_send_dat[c*ring_width_p +: ring_width_p] = w_word.payload;
                w_rdat                                    = bus.data_i[c*ring_width_p +: ring_width_p];
            end
        end
    end

    assign w_v_sel    = |(w_sel & bus.v_i);
    assign w_yumi_sel = |(w_sel & bus.yumi_i);

    bsg_trace_mc_stall_timer #(
        .cnt_w_p   (lp_cnt_w),
        .timeout_p (timeout_p)
    ) u_timer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .i_load        (w_load),
        .i_load_val    (w_load_val),
        .i_inc         (w_inc),
        .i_dec         (w_dec),
        .i_clr         (w_adv),
        .o_hit_one     (w_hit_one),
        .o_hit_timeout (w_hit_to)
    );

    // Next-state and handshake decode; nothing is offered or taken during reset or with en_i low.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_err       = 1'b0;
        w_set_done  = 1'b0;
        w_stall     = 1'b0;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        w_v_o       = '0;
        w_ready_o   = '0;
        w_data_o    = '0;

        case (r_state)
            eRUN: begin
                if (en_i && !reset_i) begin
                    if (!w_ch_ok) begin
                        w_err       = 1'b1;
                        w_state_nxt = eHALT;
                    end else begin
                        case (w_word.op)
                            e_nop: w_adv = 1'b1;
                            e_send: begin
                                w_v_o    = w_sel;
                                w_data_o = w_send_dat;
                                if (w_yumi_sel) w_adv   = 1'b1;
                                else            w_stall = 1'b1;
                            end
                            e_recv, e_recv_any: begin
                                w_ready_o = w_sel;
                                if (w_v_sel) begin
                                    w_adv = 1'b1;
                                    if ((w_word.op == e_recv) && (w_rdat != w_word.payload)) begin
                                        w_err = 1'b1;
                                    end
                                end else begin
                                    w_stall = 1'b1;
                                end
                            end
                            e_done: begin
                                w_set_done = 1'b1;
                                w_adv      = 1'b1;
                            end
                            e_finish: begin
                                w_set_done  = 1'b1;
                                w_state_nxt = eHALT;
                            end
                            e_wait: begin
                                if (w_wait_n <= lp_cyc_one) begin
                                    w_adv = 1'b1;
                                end else begin
                                    w_load      = 1'b1;
                                    w_state_nxt = eWAIT;
                                end
                            end
                            default: begin
                                w_err       = 1'b1;
                                w_state_nxt = eHALT;
                            end
                        endcase
                        if (w_stall) begin
                            if (w_hit_to) begin
                                w_err       = 1'b1;
                                w_state_nxt = eHALT;
                            end else begin
                                w_inc = 1'b1;
                            end
                        end
                    end
                end
            end
            eWAIT: begin
                if (en_i && !reset_i) begin
                    if (w_hit_one) begin
                        w_adv       = 1'b1;
                        w_state_nxt = eRUN;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State, trace pointer and sticky status; the error address keeps only the first error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= eRUN;
            r_addr     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_adv)      r_addr <= r_addr + lp_addr_one;
            if (w_set_done) r_done <= 1'b1;
            if (w_err) begin
                r_err <= 1'b1;
                if (!r_err) r_err_addr <= r_addr;
            end
        end
    end

    assign bus.v_o        = w_v_o;
    assign bus.ready_o    = w_ready_o;
    assign bus.data_o     = w_data_o;
    assign bus.rom_addr_o = r_addr;
    assign done_o         = r_done;
    assign error_o        = r_err;
    assign error_addr_o   = r_err_addr;
endmodule

// File: tb/tb_bsg_trace_node_master_mc.sv
// Directed and randomized replay scenarios checked against a trace-level reference model.
// Latency: n/a (testbench).
// Backpressure: the bench only asserts yumi_i on channels the model expects to be offering.
module tb_bsg_trace_node_master_mc;
    localparam int NCH   = 3;
    localparam int RW    = 16;
    localparam int AW    = 4;
    localparam int CW    = 8;
    localparam int TO    = 8;
    localparam int CHW   = 2;
    localparam int W     = 4 + CHW + RW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          en_i;
    logic          done_o;
    logic          error_o;
    logic [AW-1:0] error_addr_o;

    bsg_trace_node_master_mc_if #(
        .num_ch_p(NCH), .ring_width_p(RW), .rom_addr_width_p(AW)
    ) bus_if ();

    bsg_trace_node_master_mc #(
        .num_ch_p(NCH), .ring_width_p(RW), .rom_addr_width_p(AW),
        .cycle_width_p(CW), .timeout_p(TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .bus          (bus_if.master),
        .done_o       (done_o),
        .error_o      (error_o),
        .error_addr_o (error_addr_o)
    );

    always #5 clk = ~clk;

    logic [W-1:0] rom [DEPTH];
    assign bus_if.rom_data_i = rom[bus_if.rom_addr_o];

    int tests = 0;
    int fails = 0;

    // Reference model: trace pointer, remaining wait cycles, stall count, sticky flags.
    int m_pc, m_wait, m_stall, m_eaddr;
    bit m_done, m_err, m_halt;
    logic [NCH-1:0]    e_v, e_rdy;
    logic [NCH*RW-1:0] e_dat;
    logic [NCH-1:0]    obs_v, obs_rdy;
    logic              obs_err;

    function automatic logic [W-1:0] mk(input int op, input int ch, input int pay);
        return {op[3:0], ch[CHW-1:0], pay[RW-1:0]};
    endfunction

    function automatic void fill_nop();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    endfunction

    function automatic void cur_word(output int op, output int ch, output int pay);
        logic [W-1:0] w;
        w   = rom[m_pc];
        op  = int'(w[W-1 -: 4]);
        ch  = int'(w[RW +: CHW]);
        pay = int'(w[RW-1:0]);
    endfunction

    function automatic void model_out();
        int op, ch, pay;
        e_v = '0; e_rdy = '0; e_dat = '0;
        if (!reset_i && en_i && !m_halt && m_wait == 0) begin
            cur_word(op, ch, pay);
            if (ch < NCH) begin
                if (op == 1) begin
                    e_v[ch] = 1'b1;
                    e_dat[ch*RW +: RW] = pay[RW-1:0];
                end else if (op == 2 || op == 6) begin
                    e_rdy[ch] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void flag_err();
        if (!m_err) begin
            m_err   = 1'b1;
            m_eaddr = m_pc;
        end
    endfunction

    function automatic void advance();
        m_pc    = (m_pc + 1) % DEPTH;
        m_stall = 0;
    endfunction

    function automatic void stall();
        m_stall++;
        if (TO != 0 && m_stall >= TO) begin
            flag_err();
            m_halt = 1'b1;
        end
    endfunction

    function automatic void model_update();
        int op, ch, pay, n;
        if (reset_i) begin
            m_pc = 0; m_wait = 0; m_stall = 0; m_eaddr = 0;
            m_done = 0; m_err = 0; m_halt = 0;
            return;
        end
        if (m_halt || !en_i) return;
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) advance();
            return;
        end
        cur_word(op, ch, pay);
        if (ch >= NCH || op > 6) begin
            flag_err();
            m_halt = 1'b1;
            return;
        end
        case (op)
            0: advance();
            1: if (bus_if.yumi_i[ch]) advance(); else stall();
            2, 6: begin
                if (bus_if.v_i[ch]) begin
                    if (op == 2 && bus_if.data_i[ch*RW +: RW] != pay[RW-1:0]) flag_err();
                    advance();
                end else begin
                    stall();
                end
            end
            3: begin m_done = 1'b1; advance(); end
            4: begin m_done = 1'b1; m_halt = 1'b1; end
            default: begin
                n = pay % (1 << CW);
                if (n <= 1) advance(); else m_wait = n - 1;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle: inputs already driven at posedge+1; compare mid-cycle, then advance the model.
    task automatic step();
        model_out();
        #4;
        obs_v = bus_if.v_o; obs_rdy = bus_if.ready_o; obs_err = error_o;
        check("v_o",          64'(bus_if.v_o),        64'(e_v));
        check("ready_o",      64'(bus_if.ready_o),    64'(e_rdy));
        check("data_o",       64'(bus_if.data_o),     64'(e_dat));
        check("rom_addr_o",   64'(bus_if.rom_addr_o), 64'(m_pc));
        check("done_o",       64'(done_o),            64'(m_done));
        check("error_o",      64'(error_o),           64'(m_err));
        check("error_addr_o", 64'(error_addr_o),      64'(m_eaddr));
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rst, input bit en, input logic [NCH-1:0] vi,
                         input logic [NCH*RW-1:0] di, input logic [NCH-1:0] yu);
        reset_i = rst; en_i = en;
        bus_if.v_i = vi; bus_if.data_i = di; bus_if.yumi_i = yu;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, '0, '0);
    endtask

    task automatic rand_cycle(input int p_en, input int p_match);
        int op, ch, pay;
        logic [NCH*RW-1:0] di;
        reset_i = 1'b0;
        en_i    = ($urandom_range(99) < p_en);
        model_out();
        cur_word(op, ch, pay);
        for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(99) < p_match) di[c*RW +: RW] = pay[RW-1:0];
            else                              di[c*RW +: RW] = RW'($urandom);
        end
        bus_if.v_i    = NCH'($urandom);
        bus_if.data_i = di;
        bus_if.yumi_i = e_v & NCH'($urandom);
        step();
    endtask

    function automatic logic [W-1:0] rand_word();
        int r, op, ch, pay;
        r   = $urandom_range(99);
        op  = (r < 8)  ? 0 : (r < 30) ? 1 : (r < 50) ? 2 : (r < 62) ? 6 :
              (r < 67) ? 3 : (r < 70) ? 4 : (r < 85) ? 5 : (r < 97) ? 1 : $urandom_range(15, 7);
        ch  = ($urandom_range(99) < 96) ? $urandom_range(NCH - 1) : 3;
        pay = (op == 5) ? (int'($urandom & 32'hFF00) | $urandom_range(5)) : int'($urandom);
        return mk(op, ch, pay);
    endfunction

    initial begin
        int first;
        reset_i = 1'b1; en_i = 1'b0;
        bus_if.v_i = '0; bus_if.data_i = '0; bus_if.yumi_i = '0;
        fill_nop();
        m_pc = 0; m_wait = 0; m_stall = 0; m_eaddr = 0; m_done = 0; m_err = 0; m_halt = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state is checked by the model on this cycle.
        drive(1'b1, 1'b0, '0, '0, '0);

        // Send on ch1 with yumi held off for three cycles, then finish.
        fill_nop();
        rom[0] = mk(1, 1, 'hAB);
        rom[1] = mk(4, 0, 0);
        drive(1'b1, 1'b0, '0, '0, '0);
        idle(3);
        drive(1'b0, 1'b1, '0, '0, 3'b010);
        idle(3);
        check("t1_done", 64'(done_o), 64'd1);
        check("t1_addr_frozen", 64'(bus_if.rom_addr_o), 64'd1);

        // Recv compare mismatch at address 1; replay continues to done/finish.
        fill_nop();
        rom[0] = mk(2, 0, 'h55);
        rom[1] = mk(2, 0, 'h66);
        rom[2] = mk(3, 0, 0);
        rom[3] = mk(4, 0, 0);
        drive(1'b1, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b1, 3'b001, 48'h55, '0);
        drive(1'b0, 1'b1, 3'b001, 48'h77, '0);
        idle(3);
        check("t2_error", 64'(error_o), 64'd1);
        check("t2_error_addr", 64'(error_addr_o), 64'd1);
        check("t2_done", 64'(done_o), 64'd1);

        // Wait 4 then send: v_o[0] appears 4 cycles after the wait is decoded.
        fill_nop();
        rom[0] = mk(5, 0, 4);
        rom[1] = mk(1, 0, 1);
        drive(1'b1, 1'b0, '0, '0, '0);
        first = -1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, '0, '0, '0);
            if (obs_v[0] && first < 0) first = k;
        end
        check("t3_wait_latency", 64'(first), 64'd4);

        // Recv on ch1 never satisfied (other channels active): timeout on the 8th stall.
        fill_nop();
        rom[0] = mk(2, 1, 'h1234);
        drive(1'b1, 1'b0, '0, '0, '0);
        first = -1;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b1, 3'b101, 48'h1234_1234_1234, '0);
            if (obs_err && first < 0) first = k;
        end
        check("t4_timeout_cycle", 64'(first), 64'd8);
        check("t4_ready_after", 64'(obs_rdy), 64'd0);
        check("t4_error_addr", 64'(error_addr_o), 64'd0);

        // Invalid opcode at address 2, then an out-of-range channel at address 2.
        fill_nop();
        rom[2] = mk(9, 0, 0);
        drive(1'b1, 1'b0, '0, '0, '0);
        idle(5);
        check("t5_badop_err", 64'(error_o), 64'd1);
        check("t5_badop_addr", 64'(error_addr_o), 64'd2);
        check("t5_badop_halt", 64'(bus_if.rom_addr_o), 64'd2);
        rom[2] = mk(1, 3, 5);
        drive(1'b1, 1'b0, '0, '0, '0);
        idle(5);
        check("t5_badch_err", 64'(error_o), 64'd1);
        check("t5_badch_addr", 64'(error_addr_o), 64'd2);
        check("t5_badch_vo", 64'(obs_v), 64'd0);

        // Reset during a pending send abandons it.
        fill_nop();
        rom[0] = mk(1, 2, 'hBEEF);
        drive(1'b1, 1'b0, '0, '0, '0);
        idle(2);
        drive(1'b1, 1'b1, '0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, '0);
        check("t6_reset_addr", 64'(bus_if.rom_addr_o), 64'd0);
        check("t6_reset_vo", 64'(obs_v), 64'd0);

        // en_i low for 5 cycles inside a wait of 6 holds the wait counter.
        rom[0] = mk(5, 0, 6);
        rom[1] = mk(1, 0, 7);
        drive(1'b1, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b1, '0, '0, '0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, '0, '0, '0);
        first = -1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, '0, '0, '0);
            if (obs_v[0] && first < 0) first = k;
        end
        check("t6_wait_hold", 64'(first), 64'd5);

        // Randomized traces against the model.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
            drive(1'b1, 1'b0, '0, '0, '0);
            for (int k = 0; k < 250; k++) rand_cycle(70 + 4 * it, 80);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
